uart_rx: RTL and testbench

UART receiver that deserialises an asynchronous 8N1 serial line into bytes and presents each byte on a level/acknowledge handshake. It sits directly upstream of the byte-to-word assembler. Its `out_data_ready` / `byte_out` drive the assembler's byte input, and the assembler's acknowledge returns on `in_akn`. A one-entry holding register absorbs one frame of acknowledge latency; framing and overrun errors are flagged.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 36 +++
 rtl/sync_2ff.sv | 33 +++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (receiver now, transmitter later).
//   uart_rx_state_t           : receive FSM states
//   UART_DATA_BITS            : data bits per frame (8N1)
//   UART_CLKS_PER_BIT_DEFAULT : 100 MHz / 115200 baud
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Byte handshake between the UART receiver and its consumer.
//   out_data_ready : byte_out holds a valid, unacknowledged byte (rx -> consumer)
//   byte_out       : received byte, LSB first on the line      (rx -> consumer)
//   frame_err      : one-cycle pulse, bad stop bit              (rx -> consumer)
//   overrun        : one-cycle pulse, byte dropped              (rx -> consumer)
//   in_akn         : consumer has taken byte_out                (consumer -> rx)
// master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_if;
  import uart_pkg::*;

  logic                      out_data_ready;
  logic [UART_DATA_BITS-1:0] byte_out;
  logic                      frame_err;
  logic                      overrun;
  logic                      in_akn;

  modport master (
    output out_data_ready,
    output byte_out,
    output frame_err,
    output overrun,
    input  in_akn
  );

  modport slave (
    input  out_data_ready,
    input  byte_out,
    input  frame_err,
    input  overrun,
    output in_akn
  );

endinterface : uart_rx_if

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for signals asynchronous to clk.
//   clk, rst : clock, asynchronous active-high reset
//   i_d      : asynchronous input
//   o_q      : synchronized output (2 cycles latency), resets to RST_VAL
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with a one-entry holding register in front of a
// level/acknowledge byte output.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   rx   : serial line, asynchronous, idle high
//   bus  : uart_rx_if.master (out_data_ready, byte_out, frame_err, overrun,
//          in_akn)
// Parameter CLKS_PER_BIT (>= 4): clock cycles per bit.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  uart_rx_if.master  bus
);

  localparam int                 CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]   HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         LAST_IDX = 3'(UART_DATA_BITS - 1);

  logic                      w_rxs;
  logic                      r_rxs_d;

  uart_rx_state_t            r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [2:0]                r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_frame_err;

  logic [UART_DATA_BITS-1:0] r_hold;
  logic                      r_pend;
  logic [UART_DATA_BITS-1:0] r_byte_out;
  logic                      r_odr;
  logic                      r_overrun;

  logic                      w_cnt_full;
  logic                      w_data_smp;
  logic                      w_complete;
  logic                      w_load_hold;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rxs)
  );

  // Delayed copy for falling-edge (start) detection; idle-high reset value
  // keeps a reset release from looking like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rxs_d <= 1'b1;
    else     r_rxs_d <= w_rxs;
  end

  assign w_cnt_full  = (r_cnt == FULL_CNT);
  assign w_data_smp  = (r_state == DATA) && w_cnt_full;
  assign w_complete  = (r_state == STOP) && w_cnt_full && w_rxs;
  // A completion is accepted unless both buffer stages are occupied; when the
  // output register is free, hold drains this same cycle so it may reload.
  assign w_load_hold = w_complete && !(r_pend && r_odr);

  // Receive FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_rxs_d && !w_rxs) begin
            r_cnt   <= '0;
            r_state <= START;
          end
        end
        START: begin
          if (r_cnt == HALF_CNT) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            // Line back high at mid-start: treat as a glitch.
            r_state <= w_rxs ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (w_cnt_full) begin
            r_cnt <= '0;
            if (r_idx == LAST_IDX) r_state <= STOP;
            else                   r_idx   <= r_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (w_cnt_full) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            if (!w_rxs) r_frame_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Shift register and holding data carry no reset; their validity is
  // tracked by the FSM and by r_pend.
  always_ff @(posedge clk) begin
    if (w_data_smp) r_shift[r_idx] <= w_rxs;
  end

  always_ff @(posedge clk) begin
    if (w_load_hold) r_hold <= r_shift;
  end

  // Buffering: hold -> output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_odr      <= 1'b0;
      r_byte_out <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_odr && bus.in_akn) r_odr <= 1'b0;
      if (r_pend && !r_odr) begin
        r_byte_out <= r_hold;
        r_odr      <= 1'b1;
        r_pend     <= 1'b0;
      end
      // Later assignment wins: a same-cycle completion keeps pend set.
      if (w_complete) begin
        if (r_pend && r_odr) r_overrun <= 1'b1;
        else                 r_pend    <= 1'b1;
      end
    end
  end

  assign bus.out_data_ready = r_odr;
  assign bus.byte_out       = r_byte_out;
  assign bus.frame_err      = r_frame_err;
  assign bus.overrun        = r_overrun;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
  // posedge count from start-bit drive to out_data_ready first seen high
  localparam int LAT = 156;

  typedef struct {
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic auto_akn = 1'b0;
  logic man_akn  = 1'b0;

  uart_rx_if bus ();

  always_comb bus.in_akn = auto_akn | man_akn;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  bit   ack_en = 1'b1;
  int   ack_delay = 3;
  int   auto_cnt = 0;

  logic       akn_s = 1'b0, odr_s = 1'b0;
  logic       prev_odr = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;
  logic [7:0] captured = 8'h00;

  always @(posedge clk) begin
    akn_s <= bus.in_akn;
    odr_s <= bus.out_data_ready;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (auto_cnt > 0) begin
      auto_cnt--;
      auto_akn = (auto_cnt == 0);
    end else begin
      auto_akn = 1'b0;
    end

    if (akn_s && odr_s) check("odr_fall_after_akn", int'(bus.out_data_ready), 0);

    if (bus.out_data_ready && !prev_odr) begin
      if (q.size() == 0) begin
        check("unexpected_byte", int'(bus.byte_out), -1);
      end else begin
        e = q.pop_front();
        check("byte_out", int'(bus.byte_out), int'(e.data));
        if (e.exp_cyc >= 0) check("ready_latency", cyc, e.exp_cyc);
        if (ack_en) auto_cnt = ack_delay;
      end
      captured = bus.byte_out;
    end else if (bus.out_data_ready && prev_odr) begin
      check("byte_out_stable", int'(bus.byte_out), int'(captured));
    end

    if (bus.frame_err) fe_cnt++;
    if (bus.overrun)   ov_cnt++;
    if (bus.frame_err && prev_fe) check("frame_err_width", 2, 1);
    if (bus.overrun && prev_ov)   check("overrun_width", 2, 1);

    prev_odr = bus.out_data_ready;
    prev_fe  = bus.frame_err;
    prev_ov  = bus.overrun;
  end

  // Must be called at a negedge; returns at a negedge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input bit push, input bit timed);
    exp_t e;
    if (push) begin
      e.data    = d;
      e.exp_cyc = timed ? cyc + LAT : -1;
      q.push_back(e);
    end
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while ((q.size() != 0 || bus.out_data_ready) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(q.size() != 0 || bus.out_data_ready), 0);
  endtask

  task automatic man_ack();
    man_akn = 1'b1;
    @(negedge clk);
    man_akn = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_odr"},       int'(bus.out_data_ready), 0);
    check({tag, "_byte_out"},  int'(bus.byte_out), 0);
    check({tag, "_frame_err"}, int'(bus.frame_err), 0);
    check({tag, "_overrun"},   int'(bus.overrun), 0);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame, timed
    ack_en = 1'b1; ack_delay = 3;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    wait_drain("drain_a5", 400);
    check("a5_frame_err_cnt", fe_cnt, 0);
    check("a5_overrun_cnt", ov_cnt, 0);

    // Back-to-back, slow consumer
    ack_delay = 40;
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    send_frame(8'h80, 1'b1, 1'b1, 1'b0);
    wait_drain("drain_01_80", 600);

    // Three back-to-back frames, no ack: third overruns
    ack_en = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("overrun_cnt", ov_cnt, 1);
    check("held_byte_11", int'(bus.byte_out), 8'h11);
    man_ack();
    repeat (5) @(negedge clk);
    check("second_byte_22", int'(bus.byte_out), 8'h22);
    man_ack();
    repeat (60) @(negedge clk);
    check("no_byte_33", int'(q.size() != 0 || bus.out_data_ready), 0);
    check("overrun_cnt_final", ov_cnt, 1);

    // Framing error then good frame
    ack_en = 1'b1; ack_delay = 3;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("frame_err_cnt", fe_cnt, 1);
    check("frame_err_no_ready", int'(bus.out_data_ready), 0);
    repeat (10) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    wait_drain("drain_5a", 400);

    // Glitch on the line
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_frame_err_cnt", fe_cnt, 1);
    check("glitch_state_idle", int'(dut.r_state), int'(IDLE));
    check("glitch_no_ready", int'(bus.out_data_ready), 0);

    // Reset mid-frame
    fork
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      begin
        repeat (70) @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(negedge clk);
        check("midreset_state_idle", int'(dut.r_state), int'(IDLE));
        rst = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("no_byte_ff", int'(q.size() != 0 || bus.out_data_ready), 0);
    send_frame(8'h42, 1'b1, 1'b1, 1'b0);
    wait_drain("drain_42", 400);
    check("final_frame_err_cnt", fe_cnt, 1);
    check("final_overrun_cnt", ov_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx
